vga_render_ctrl: RTL and testbench
==================================

Name: vga_render_ctrl

Overview:
- Timing and sequencing controller for the pixel render datapath.
- Generates the raster scan, i.e. the horizontal and vertical counters plus the sync signals.
- Drives the pixel coordinates used by the map and player pixel sources.
- Produces the display-enable and map-enable strobes that select between map/player colour, the out-of-map border colour and black. These strobes are delayed so they line up with the pixel-source fetch latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- MAP_X0, 64, left edge of the map window in screen pixels
- MAP_Y0, 48, top edge of the map window in screen lines
- MAP_W, 512, map window width; MAP_X0+MAP_W <= H_ACTIVE
- MAP_H, 384, map window height; MAP_Y0+MAP_H <= V_ACTIVE
- PIPE_LAT, 2, pixel-source fetch latency in pixel ticks; legal range 1..4

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- pix_en_i  in  1  pixel tick; all raster state advances only when this is 1
- run_i  in  1  scan enable; 0 holds the raster at the origin, blanked
- pixel_x_o  out  HW  fetch-stage screen x, where HW = $clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)
- pixel_y_o  out  VW  fetch-stage screen y, where VW = $clog2(V total)
- map_x_o  out  HW  fetch-stage x relative to MAP_X0; 0 outside the map window
- map_y_o  out  VW  fetch-stage y relative to MAP_Y0; 0 outside the map window
- frame_start_o  out  1  one-clock pulse when fetch coordinates become (0,0)
- display_enable_o  out  1  active-area strobe, delayed PIPE_LAT ticks
- map_enable_o  out  1  inside-map-window strobe, delayed PIPE_LAT ticks
- hsync_o  out  1  active-low horizontal sync, delayed PIPE_LAT ticks
- vsync_o  out  1  active-low vertical sync, delayed PIPE_LAT ticks

Behaviour:
- Reset values, asynchronous on rst_ni=0:
  - hcnt=0, vcnt=0, all coordinate outputs 0.
  - frame_start_o=0, display_enable_o=0, map_enable_o=0.
  - hsync_o=1, vsync_o=1.
  - Delay line filled with the blank pattern (de=0, men=0, hs=1, vs=1).
- Horizontal FSM (H_ACT, H_FRONT, H_SYNC, H_BACK), updated on pix_en_i only:
  - H_ACT -> H_FRONT at hcnt=H_ACTIVE-1.
  - H_FRONT -> H_SYNC at hcnt=H_ACTIVE+H_FP-1.
  - H_SYNC -> H_BACK at hcnt=H_ACTIVE+H_FP+H_SYNC-1.
  - H_BACK -> H_ACT at hcnt=H_TOTAL-1, where hcnt wraps to 0 and the line-end event fires.
- Vertical FSM (V_ACT, V_FRONT, V_SYNC, V_BACK): same structure on vcnt. It advances only on the line-end event; vcnt wraps at V_TOTAL-1.
- Fetch stage, registered on each pix_en_i:
  - pixel_x_o=hcnt, pixel_y_o=vcnt.
  - Inside the map window (MAP_X0 <= hcnt < MAP_X0+MAP_W, and the same rule for y): map_x_o=hcnt-MAP_X0 and map_y_o=vcnt-MAP_Y0; otherwise both are 0. Subtraction is unsigned at HW/VW width with no wrap, because the window check guards it.
- Stage-0 flags:
  - de = H_ACT && V_ACT.
  - men = de && inside map window.
  - hs = !(H_SYNC).
  - vs = !(V_SYNC).
- Delay line:
  - Stage-0 flags pass through PIPE_LAT registers that shift only on pix_en_i.
  - The outputs are the last stage. Flags for fetch coordinate (x,y) appear exactly PIPE_LAT ticks after (x,y) appears on pixel_x_o/pixel_y_o.
- frame_start_o:
  - Asserted for one clk_i cycle, on the clock edge that loads (0,0) into the fetch stage.
  - Never asserted for more than one cycle, even when pix_en_i is held high.
- pix_en_i=0: every register holds, and frame_start_o=0.
- run_i=0, synchronous:
  - Next clock: counters and fetch stage go to 0, FSMs go to H_ACT/V_ACT, the delay line is reloaded with the blank pattern, frame_start_o=0. This applies regardless of pix_en_i.
  - When run_i returns to 1, the first pix_en_i tick loads (0,0) and pulses frame_start_o.
- Simultaneous events:
  - Line end and frame end on the same tick: both counters wrap, and frame_start_o pulses.
  - run_i=0 takes priority over pix_en_i.
- Boundaries:
  - MAP_W or MAP_H equal to 0 means men is never asserted.
  - A map window touching the active-area edge is legal.

Decomposition:
- Package vga_pkg holds:
  - typedef enum logic [1:0] {PH_ACT, PH_FRONT, PH_SYNC, PH_BACK} phase_e, shared by both FSMs.
  - 640x480@60 default timing localparams.
  - Blank-flags constant {de=0, men=0, hs=1, vs=1}.
- One sub-module, vga_delay_line: parameterised width and depth (PIPE_LAT), with shift enable, synchronous flush-to-constant, and asynchronous reset to the same constant.

Test Plan:
- Reset: assert rst_ni=0 mid-frame -> immediately all coordinates 0, de=0, men=0, hsync_o=1, vsync_o=1, frame_start_o=0.
- Small timing (H 8/2/3/1, V 4/1/1/1, PIPE_LAT=2, pix_en_i=1 every cycle):
  - Line period is 14 clocks and frame period is 98 clocks.
  - hsync_o is low for 3 clocks, starting 2 clocks after pixel_x_o=10.
- Map window MAP_X0=2, MAP_W=4, MAP_Y0=1, MAP_H=2:
  - On line 1, map_x_o runs 0,1,2,3 while pixel_x_o runs 2..5, and is 0 elsewhere.
  - map_enable_o is high for exactly 4 clocks, 2 clocks later than that run.
  - Lines 0 and 3: map_enable_o stays 0.
- pix_en_i toggling 1,0,1,0:
  - Counters advance on alternate clocks only, so the line period is 28 clocks.
  - frame_start_o stays a single 1-clock pulse per frame.
- run_i=0 at pixel_x_o=5, line 2:
  - Next clock: coordinates 0, display_enable_o=0, hsync_o=1.
  - After run_i=1, the first tick gives pixel_x_o=0, pixel_y_o=0 and frame_start_o=1 for one clock.
- Frame wrap:
  - After hcnt=13, vcnt=6, the next tick loads (0,0) and frame_start_o pulses.
  - vsync_o, low during line 5 at the delayed position, returns high.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA render controller.
package vga_pkg;

    // Phase of a raster axis; the horizontal and vertical FSMs share this encoding.
    typedef enum logic [1:0] {
        PH_ACT,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    // Default 640x480@60 timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Default map window and pixel-source latency.
    localparam int DEF_MAP_X0    = 64;
    localparam int DEF_MAP_Y0    = 48;
    localparam int DEF_MAP_W     = 512;
    localparam int DEF_MAP_H     = 384;
    localparam int DEF_PIPE_LAT  = 2;

    // Per-pixel strobes carried down the delay line alongside the fetch.
    typedef struct packed {
        logic de;   // display enable
        logic men;  // map enable
        logic hs;   // active-low hsync
        logic vs;   // active-low vsync
    } flags_t;

    // Blanked pixel: no display, no map, both syncs inactive (high).
    localparam flags_t BLANK_FLAGS = '{de: 1'b0, men: 1'b0, hs: 1'b1, vs: 1'b1};

    // Next phase of one raster axis given the count that is about to be left behind.
    function automatic phase_e next_phase(
        input phase_e      ph,
        input int unsigned cnt,
        input int unsigned act_len,
        input int unsigned fp_len,
        input int unsigned sync_len,
        input int unsigned bp_len
    );
        phase_e nxt;
        nxt = ph;
        unique case (ph)
            PH_ACT:   if (cnt == act_len - 1)                            nxt = PH_FRONT;
            PH_FRONT: if (cnt == act_len + fp_len - 1)                   nxt = PH_SYNC;
            PH_SYNC:  if (cnt == act_len + fp_len + sync_len - 1)        nxt = PH_BACK;
            PH_BACK:  if (cnt == act_len + fp_len + sync_len + bp_len - 1) nxt = PH_ACT;
            default:                                                     nxt = PH_ACT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift-enabled delay line that lines the pixel strobes up with the pixel-source fetch latency.
module vga_delay_line #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             shift_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Stage shift register: async reset and sync flush both load the blank constant.
    // NOTE: this is a few flops, so every stage is reset; a RAM-sized buffer would be left unreset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else if (shift_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_render_ctrl.sv
// Raster timing, fetch-stage coordinates and latency-matched strobes for the pixel render path.
module vga_render_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int MAP_X0   = DEF_MAP_X0,
    parameter int MAP_Y0   = DEF_MAP_Y0,
    parameter int MAP_W    = DEF_MAP_W,
    parameter int MAP_H    = DEF_MAP_H,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pix_en_i,
    input  logic          run_i,
    output logic [HW-1:0] pixel_x_o,
    output logic [VW-1:0] pixel_y_o,
    output logic [HW-1:0] map_x_o,
    output logic [VW-1:0] map_y_o,
    output logic          frame_start_o,
    output logic          display_enable_o,
    output logic          map_enable_o,
    output logic          hsync_o,
    output logic          vsync_o
);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] MAP_X0_W  = HW'(MAP_X0);
    localparam logic [VW-1:0] MAP_Y0_W  = VW'(MAP_Y0);

    // Raster state
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    phase_e        hphase_q, hphase_d;
    phase_e        vphase_q, vphase_d;
    logic          line_end;

    // Fetch stage
    logic [HW-1:0] pixel_x_q, map_x_d, map_x_q;
    logic [VW-1:0] pixel_y_q, map_y_d, map_y_q;
    logic          frame_start_q, frame_start_d;
    logic          in_map;
    flags_t        flags0_d, flags0_q, flags_out;

    // Next raster position and phases, assuming the current clock is a pixel tick.
    // NOTE: every always_comb output is assigned a default up front so no latch can be inferred.
    always_comb begin
        line_end = (hcnt_q == H_LAST);
        hphase_d = next_phase(hphase_q, 32'(hcnt_q), H_ACTIVE, H_FP, H_SYNC, H_BP);
        hcnt_d   = line_end ? '0 : hcnt_q + HW'(1);
        vphase_d = vphase_q;
        vcnt_d   = vcnt_q;
        if (line_end) begin
            vphase_d = next_phase(vphase_q, 32'(vcnt_q), V_ACTIVE, V_FP, V_SYNC, V_BP);
            vcnt_d   = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end
    end

    // Counter and phase FSM registers: cleared by run_i=0, advanced on each pixel tick.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hphase_q <= PH_ACT;
            vphase_q <= PH_ACT;
        end else if (!run_i) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hphase_q <= PH_ACT;
            vphase_q <= PH_ACT;
        end else if (pix_en_i) begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hphase_q <= hphase_d;
            vphase_q <= vphase_d;
        end
    end

    // Map-window coordinates and stage-0 strobes for the current raster position.
    always_comb begin
        in_map = (int'(hcnt_q) >= MAP_X0) && (int'(hcnt_q) < MAP_X0 + MAP_W) &&
                 (int'(vcnt_q) >= MAP_Y0) && (int'(vcnt_q) < MAP_Y0 + MAP_H);
        map_x_d = in_map ? hcnt_q - MAP_X0_W : '0;
        map_y_d = in_map ? vcnt_q - MAP_Y0_W : '0;

        flags0_d     = BLANK_FLAGS;
        flags0_d.de  = (hphase_q == PH_ACT) && (vphase_q == PH_ACT);
        flags0_d.men = flags0_d.de && in_map;
        flags0_d.hs  = (hphase_q != PH_SYNC);
        flags0_d.vs  = (vphase_q != PH_SYNC);

        frame_start_d = pix_en_i && (hcnt_q == '0) && (vcnt_q == '0);
    end

    // Fetch-stage registers: coordinates, stage-0 strobes and the frame-start pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            map_x_q       <= '0;
            map_y_q       <= '0;
            flags0_q      <= BLANK_FLAGS;
            frame_start_q <= 1'b0;
        end else if (!run_i) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            map_x_q       <= '0;
            map_y_q       <= '0;
            flags0_q      <= BLANK_FLAGS;
            frame_start_q <= 1'b0;
        end else begin
            // Pulse lasts one clock: it is recomputed every clock, ticks or not.
            frame_start_q <= frame_start_d;
            if (pix_en_i) begin
                pixel_x_q <= hcnt_q;
                pixel_y_q <= vcnt_q;
                map_x_q   <= map_x_d;
                map_y_q   <= map_y_d;
                flags0_q  <= flags0_d;
            end
        end
    end

    // Strobes reach the outputs PIPE_LAT ticks after their coordinate enters the fetch stage.
    vga_delay_line #(
        .WIDTH   ($bits(flags_t)),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (BLANK_FLAGS)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .shift_i (run_i && pix_en_i),
        .flush_i (!run_i),
        .d_i     (flags0_q),
        .q_o     (flags_out)
    );

    assign pixel_x_o        = pixel_x_q;
    assign pixel_y_o        = pixel_y_q;
    assign map_x_o          = map_x_q;
    assign map_y_o          = map_y_q;
    assign frame_start_o    = frame_start_q;
    assign display_enable_o = flags_out.de;
    assign map_enable_o     = flags_out.men;
    assign hsync_o          = flags_out.hs;
    assign vsync_o          = flags_out.vs;

endmodule

// File: tb/tb_vga_render_ctrl.sv
// Self-checking bench for vga_render_ctrl on a tiny raster, against a position-based reference model.
module tb_vga_render_ctrl;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int MX0 = 2, MY0 = 1, MW = 4, MH = 2;
    localparam int PL = 2;
    localparam int HT = HA + HF + HS + HB;   // 14
    localparam int VT = VA + VF + VS + VB;   // 7
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam logic [3:0] BLANK = 4'b0011; // {de, men, hs, vs}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b1;
    logic          pen = 1'b0;
    logic [HW-1:0] pixel_x, map_x;
    logic [VW-1:0] pixel_y, map_y;
    logic          frame_start, display_enable, map_enable, hsync, vsync;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         mh, mv, fx, fy, fmx, fmy;
    bit         mfs;
    logic [3:0] hist [0:PL];

    // Frame-level measurements
    int last_fs, men_cnt;

    vga_render_ctrl #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .MAP_X0 (MX0), .MAP_Y0 (MY0), .MAP_W (MW), .MAP_H (MH),
        .PIPE_LAT (PL)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .pix_en_i         (pen),
        .run_i            (run),
        .pixel_x_o        (pixel_x),
        .pixel_y_o        (pixel_y),
        .map_x_o          (map_x),
        .map_y_o          (map_y),
        .frame_start_o    (frame_start),
        .display_enable_o (display_enable),
        .map_enable_o     (map_enable),
        .hsync_o          (hsync),
        .vsync_o          (vsync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Strobes for a screen position, straight from the porch/sync/window arithmetic.
    function automatic logic [3:0] flags_of(input int h, input int v);
        bit de, inm, hs, vs;
        de  = (h < HA) && (v < VA);
        inm = (h >= MX0) && (h < MX0 + MW) && (v >= MY0) && (v < MY0 + MH);
        hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        return {de, de && inm, hs, vs};
    endfunction

    task automatic model_clear();
        mh = 0; mv = 0; fx = 0; fy = 0; fmx = 0; fmy = 0; mfs = 1'b0;
        for (int k = 0; k <= PL; k++) hist[k] = BLANK;
    endtask

    task automatic model_step();
        bit inm;
        if (!run) begin
            model_clear();
        end else if (pen) begin
            mfs = (mh == 0) && (mv == 0);
            fx  = mh;
            fy  = mv;
            inm = (mh >= MX0) && (mh < MX0 + MW) && (mv >= MY0) && (mv < MY0 + MH);
            fmx = inm ? mh - MX0 : 0;
            fmy = inm ? mv - MY0 : 0;
            for (int k = PL; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = flags_of(mh, mv);
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end else begin
            mfs = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("pixel_x", 32'(pixel_x), fx);
        check("pixel_y", 32'(pixel_y), fy);
        check("map_x", 32'(map_x), fmx);
        check("map_y", 32'(map_y), fmy);
        check("frame_start", 32'(frame_start), int'(mfs));
        check("display_enable", 32'(display_enable), int'(hist[PL][3]));
        check("map_enable", 32'(map_enable), int'(hist[PL][2]));
        check("hsync", 32'(hsync), int'(hist[PL][1]));
        check("vsync", 32'(vsync), int'(hist[PL][0]));
    endtask

    // Drive inputs at the falling edge, step the model at the rising edge, compare at the next falling edge.
    task automatic step(input logic r, input logic p);
        run = r;
        pen = p;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic frame_track(input int cyc, input int exp_period, input int exp_men);
        if (map_enable) men_cnt++;
        if (frame_start) begin
            if (last_fs >= 0) begin
                check("frame_period", 32'(cyc - last_fs), exp_period);
                check("men_per_frame", 32'(men_cnt), exp_men);
            end
            last_fs = cyc;
            men_cnt = 0;
        end
    endtask

    initial begin
        bit found;

        // Power-on reset
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Continuous ticks: 98-clock frames, 8 map-enable clocks per frame
        last_fs = -1; men_cnt = 0;
        for (int c = 0; c < 250; c++) begin
            step(1'b1, 1'b1);
            frame_track(c, HT * VT, MW * MH);
        end

        // Alternate ticks: everything stretches by two
        last_fs = -1; men_cnt = 0;
        for (int c = 0; c < 500; c++) begin
            step(1'b1, (c % 2) == 0);
            frame_track(c, 2 * HT * VT, 2 * MW * MH);
        end

        // Random ticks with rare scan stops
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 399) != 0, $urandom_range(0, 3) != 0);
        end

        // Stop the scan at x=5 on line 2, then restart
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            step(1'b1, 1'b1);
            if (pixel_x == HW'(5) && pixel_y == VW'(2)) found = 1'b1;
        end
        check("found_x5_y2", 32'(found), 1);
        step(1'b0, 1'b1);
        check("run0_pixel_x", 32'(pixel_x), 0);
        check("run0_display_enable", 32'(display_enable), 0);
        check("run0_hsync", 32'(hsync), 1);
        step(1'b1, 1'b1);
        check("restart_frame_start", 32'(frame_start), 1);
        check("restart_pixel_x", 32'(pixel_x), 0);
        check("restart_pixel_y", 32'(pixel_y), 0);
        step(1'b1, 1'b1);
        check("restart_pulse_width", 32'(frame_start), 0);

        // Frame wrap from the last raster position
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            step(1'b1, 1'b1);
            if (pixel_x == HW'(HT - 1) && pixel_y == VW'(VT - 1)) found = 1'b1;
        end
        check("found_frame_end", 32'(found), 1);
        step(1'b1, 1'b1);
        check("wrap_frame_start", 32'(frame_start), 1);
        check("wrap_pixel_x", 32'(pixel_x), 0);
        check("wrap_pixel_y", 32'(pixel_y), 0);
        for (int c = 0; c < 37; c++) step(1'b1, $urandom_range(0, 1) != 0);

        // Asynchronous reset in the middle of a frame
        #2 rst_n = 1'b0;
        #1;
        check("rst_pixel_x", 32'(pixel_x), 0);
        check("rst_pixel_y", 32'(pixel_y), 0);
        check("rst_map_x", 32'(map_x), 0);
        check("rst_map_y", 32'(map_y), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_display_enable", 32'(display_enable), 0);
        check("rst_map_enable", 32'(map_enable), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        for (int c = 0; c < 150; c++) step(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
